// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared state encodings, width defaults and op codes for mem_arbiter_2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
//  Module   : rr_arbiter_2
//  Purpose  : Two-way arbiter; round-robin by default, fixed priority (req[0]
//             wins) when MEM_ARB_FIXED_PRIO_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       last
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    assign last     = 1'b1;
    assign w_unused = ^{clk, rst, en};
`else
    // r_last holds the index of the requester served most recently.
    logic r_last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            r_last <= grant[1];
        end
    end

    assign last = r_last;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_2.sv
// ============================================================================
//  Module   : mem_arbiter_2
//  Purpose  : Two-client sequencer for a 16x8 synchronous memory; owns the
//             mem_data turnaround. MEM_ARB_FIXED_PRIO_EN selects fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_2
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    state_t          r_state;
    logic            r_op;
    logic            r_sel;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic [1:0]      w_grant;
    logic            w_last_served;
    logic            w_unused;
    logic            w_win_op;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_wdata;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({req1, req0}),
        .en    (r_state == IDLE),
        .grant (w_grant),
        .last  (w_last_served)
    );

    assign w_unused    = w_last_served;
    assign w_win_op    = w_grant[1] ? wr1    : wr0;
    assign w_win_addr  = w_grant[1] ? addr1  : addr0;
    assign w_win_wdata = w_grant[1] ? wdata1 : wdata0;

    // mem_we is a register, so the bus is released exactly when the write cycle ends.
    assign mem_data = mem_we ? r_wdata : {DW{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_RD;
            r_sel    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_addr <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_sel   <= w_grant[1];
                        r_op    <= w_win_op;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        gnt0    <= w_grant[0];
                        gnt1    <= w_grant[1];
                        r_state <= (w_win_op == OP_WR) ? WR : RD1;
                    end
                end
                WR: begin
                    mem_we   <= 1'b1;
                    mem_addr <= r_addr;
                    r_state  <= DONE;
                end
                RD1: begin
                    mem_oe   <= 1'b1;
                    mem_addr <= r_addr;
                    r_state  <= RD2;
                end
                RD2: begin
                    mem_oe  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    // Memory drives its registered word during the second oe cycle.
                    if (r_op == OP_RD) begin
                        rdata <= mem_data;
                    end
                    mem_we  <= 1'b0;
                    mem_oe  <= 1'b0;
                    ack0    <= ~r_sel;
                    ack1    <= r_sel;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_2.sv
// ============================================================================
//  Module   : tb_mem_arbiter_2
//  Purpose  : Self-checking bench for mem_arbiter_2 with a 16x8 memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter_2;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, wr0, req1, wr1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, ack0, gnt1, ack1;
    logic [7:0] rdata;
    logic       mem_we, mem_oe;
    logic [3:0] mem_addr;
    wire  [7:0] mem_data;

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;
    int glog[$];

    typedef struct {
        bit         wr;
        logic [7:0] rdata;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        bit         id;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[34];

    mem_arbiter_2 dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
        .rdata(rdata), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // 16x8 synchronous memory: write on we, registered read word driven while oe.
    logic [7:0] mem [16];
    logic [7:0] mem_q;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        if (mem_oe) mem_q <= mem[mem_addr];
    end
    assign mem_data = mem_oe ? mem_q : 8'hzz;

    always @(negedge clk) begin
        if (mem_we && mem_oe) viol = viol + 1;
        if (!mem_we && !mem_oe && (mem_data !== 8'hzz)) viol = viol + 1;
        if (gnt0) glog.push_back(0);
        if (gnt1) glog.push_back(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic txn(input bit id, input bit wr, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit lat);
        exp_t       e;
        int         g, k;
        logic [15:0] wem, oem;
        logic [3:0]  pa;
        logic [7:0]  pd;
        e.wr = wr;
        e.rdata = exp_rd;
        if (id == 1'b0) begin
            q0.push_back(e);
            req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d;
        end else begin
            q1.push_back(e);
            req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d;
        end
        g = -1; k = -1; wem = '0; oem = '0; pa = '0; pd = '0;
        for (int n = 1; n <= 40 && k < 0; n++) begin
            @(posedge clk);
            #1;
            if (n < 16) begin
                wem[n] = mem_we;
                oem[n] = mem_oe;
            end
            if (mem_we || mem_oe) pa = mem_addr;
            if (mem_we) pd = mem_data;
            if (g < 0 && ((id == 1'b0 && gnt0) || (id == 1'b1 && gnt1))) g = n;
            if ((id == 1'b0 && ack0) || (id == 1'b1 && ack1)) k = n;
        end
        if (id == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        if (k < 0) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            if (id == 1'b0) e = q0.pop_front(); else e = q1.pop_front();
            if (!e.wr) chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
        end
        if (lat) begin
            chk("gnt_latency", g, 32'd1);
            chk("ack_latency", k, wr ? 32'd3 : 32'd4);
            chk("we_cycles", {16'd0, wem}, wr ? 32'h4 : 32'h0);
            chk("oe_cycles", {16'd0, oem}, wr ? 32'h0 : 32'hC);
            chk("mem_addr", {28'd0, pa}, {28'd0, a});
            if (wr) chk("mem_data_wr", {24'd0, pd}, {24'd0, d});
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'h3, 8'h33, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h33};
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ai;
            ai = 4'(i);
            vecs[2 + i]  = '{ai[0], 1'b1, ai, 8'(i * 8'h11), 8'h00};
            vecs[18 + i] = '{~ai[0], 1'b0, ai, 8'h00, 8'(i * 8'h11)};
        end

        rst = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {26'd0, gnt0, gnt1, ack0, ack1, mem_we, mem_oe}, 32'd0);
        chk("rst_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_bus_z", (mem_data === 8'hzz) ? 32'd1 : 32'd0, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            txn(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b1);
        end

        // Reset while the read sits in RD1: transaction must vanish without an ack.
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h5;
        @(posedge clk); #1;
        chk("rd1_gnt", {31'd0, gnt1}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req1 = 1'b0;
        chk("rst_mid_oe", {31'd0, mem_oe}, 32'd0);
        chk("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
        begin
            int acks;
            acks = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (ack0 || ack1) acks = acks + 1;
            end
            chk("rst_mid_no_ack", acks, 32'd0);
        end
        txn(1'b1, 1'b0, 4'h5, 8'h00, 8'h55, 1'b1);

        // Simultaneous requests, each requester re-asserting straight after its ack.
        glog.delete();
        fork
            begin
                txn(1'b0, 1'b1, 4'h1, 8'hA1, 8'h00, 1'b0);
                txn(1'b0, 1'b1, 4'h1, 8'hA3, 8'h00, 1'b0);
            end
            begin
                txn(1'b1, 1'b1, 4'h2, 8'hB2, 8'h00, 1'b0);
                txn(1'b1, 1'b1, 4'h2, 8'hB4, 8'h00, 1'b0);
            end
        join
        @(negedge clk);
        chk("tie_count", glog.size(), 32'd4);
        if (glog.size() == 4) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk("tie_order0", glog[0], 32'd0);
            chk("tie_order1", glog[1], 32'd0);
            chk("tie_order2", glog[2], 32'd1);
            chk("tie_order3", glog[3], 32'd1);
`else
            chk("tie_order0", glog[0], 32'd0);
            chk("tie_order1", glog[1], 32'd1);
            chk("tie_order2", glog[2], 32'd0);
            chk("tie_order3", glog[3], 32'd1);
`endif
        end
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 4'h1, 8'h00, 8'hA3, 1'b1);
        txn(1'b1, 1'b0, 4'h2, 8'h00, 8'hB4, 1'b1);

        chk("bus_rules", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
